fpu_issue_ctrl: RTL and testbench
=================================

Name: fpu_issue_ctrl

Overview:
- Issue controller and scoreboard between the FPU decoder and the FPU execution units.
- Accepts one decoded FPU operation per cycle and blocks RAW/WAW hazards on the 32 FP registers.
- Starts and tracks the iterative DIV/SQRT unit.
- Arbitrates the single FP register-file writeback port among single-cycle, fixed-latency pipelined and iterative results, and handles pipeline flush.

Parameters:
- PIPE_LAT, 3, latency in cycles of the pipelined class (must be 2..8).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- issue_valid  in  1  decoded FPU op present
- issue_op  in  FPUOper_t  decoded operation
- issue_raddr1  in  RegAddr_t  FP source 1
- issue_raddr2  in  RegAddr_t  FP source 2
- issue_we  in  Bit_t  op writes an FP register
- issue_waddr  in  RegAddr_t  FP destination
- issue_ready  out  1  op accepted this cycle when issue_valid=1
- flush  in  1  kill all unwritten results
- iter_start  out  1  one-cycle start pulse to DIV/SQRT unit
- iter_op  out  FPUOper_t  op latched for iterative unit
- iter_done  in  1  iterative result available; unit holds it until iter_ack
- iter_ack  out  1  iterative result consumed (written or discarded)
- wb_valid  out  1  FP register write this cycle
- wb_waddr  out  RegAddr_t  write address
- wb_sel  out  2  result source: 0 single, 1 pipe, 2 iter
- illegal  out  1  one-cycle pulse: FPU_OP_INVALID accepted
- busy  out  1  any pending bit set or iterative FSM not IDLE

Behaviour:
- Op classes:
  - SINGLE: LW, SW, MFC, CFC, MTC, CTC, COND.
  - PIPE: ADD, SUB, MUL, ROUND, TRUNC, CEIL, FLOOR, CVTS, CVTW.
  - ITER: DIV, SQRT.
  - INVALID: accepted, no write, illegal pulses the next cycle.
- Scoreboard: 32-bit pending mask, reset 0.
  - Bit set on the cycle after acceptance of an op with issue_we=1.
  - Bit cleared at the end of its wb_valid cycle.
  - No bypass: a register written this cycle is still pending.
- Slot reservation: shift register of PIPE_LAT entries {valid, waddr, sel}. Entry k means "writes back k cycles from now". Shifts every cycle; entry 0 drives wb_valid/wb_waddr/wb_sel.
- issue_ready=1 only when all of the following hold:
  - flush=0;
  - raddr1 and raddr2 not pending (only for ops that read them);
  - waddr not pending if issue_we;
  - SINGLE with we: slot 1 free;
  - PIPE: slot PIPE_LAT free;
  - ITER: FSM in IDLE.
- Latency: SINGLE accepted at cycle t writes at t+1; PIPE at t+PIPE_LAT. Ops with we=0 reserve nothing.
- Iterative FSM (reset IDLE):
  - IDLE -> RUN on ITER acceptance; iter_start=1 that cycle; iter_op latched.
  - RUN -> HOLD on iter_done.
  - HOLD: write when slot 0 is invalid. That cycle: wb_valid=1, wb_sel=2, iter_ack=1; -> IDLE.
  - Pipeline slot always has priority over the iterative result.
  - flush in RUN -> DRAIN. DRAIN waits for iter_done, pulses iter_ack without writing, -> IDLE.
  - flush in HOLD: iter_ack, no write, -> IDLE.
- flush:
  - Clears all slot entries and the whole pending mask at that edge.
  - Suppresses wb_valid that cycle.
  - Blocks acceptance that cycle.
  - A pending bit belonging to an op in DRAIN is also cleared.
- Reset: pending=0, slots empty, FSM IDLE. Outputs iter_start, iter_ack, wb_valid, illegal = 0; wb_waddr=0, wb_sel=0, iter_op=FPU_OP_INVALID.
- Reset mid-operation: the iterative unit is reset by the same rst; no ack is issued.

Decomposition:
- Add to the shared cpu_defs package: FPUOpClass_t enum {SINGLE, PIPE, ITER, INVALID}, FPUWbSel_t enum, and the function fpu_op_class(FPUOper_t).
- Sub-module fpu_wb_slots: the reservation shift register with reserve/flush/head ports.

Test Plan:
1. After reset, ADD f3<-f1,f2 accepted at t=1 -> wb_valid, waddr=3, sel=1 at t=4. Dependent SUB reading f3 has issue_ready=0 through t=4 and is accepted at t=5.
2. MUL f4 at t=1, then MTC f5 at t=3 -> MTC blocked at t=3 (slot 1 taken) and accepted at t=4. Writes: f4 at t=4, f5 at t=5.
3. DIV f6 at t=1 -> iter_start at t=1. Second DIV blocked until IDLE. iter_done at t=10 -> wb sel=2, iter_ack at t=11.
4. iter_done while a PIPE writeback is due at t=11 -> iterative result held. Written at t=12 with iter_ack; pipe write at t=11.
5. flush at t=2 with ADD in flight and DIV in RUN -> pending cleared, no wb at t=4. DIV done at t=9 -> iter_ack, no wb_valid. busy=0 at t=10.
6. issue_op=FPU_OP_INVALID -> issue_ready=1, illegal pulse the next cycle, no wb_valid, pending mask unchanged.

Source files
------------

// File: rtl/fpu_issue_ctrl_pkg.sv
// fpu_issue_ctrl_pkg: shared FPU operation types, op classes and issue helper functions
package fpu_issue_ctrl_pkg;
    typedef logic [4:0] RegAddr_t;
    typedef logic       Bit_t;
    typedef enum logic [4:0] {
        FPU_OP_ADD, FPU_OP_SUB, FPU_OP_MUL, FPU_OP_DIV, FPU_OP_SQRT,
        FPU_OP_ROUND, FPU_OP_TRUNC, FPU_OP_CEIL, FPU_OP_FLOOR, FPU_OP_CVTS, FPU_OP_CVTW,
        FPU_OP_LW, FPU_OP_SW, FPU_OP_MFC, FPU_OP_CFC, FPU_OP_MTC, FPU_OP_CTC, FPU_OP_COND,
        FPU_OP_INVALID
    } FPUOper_t;
    typedef enum logic [1:0] {OPC_SINGLE, OPC_PIPE, OPC_ITER, OPC_INVALID} FPUOpClass_t;
    typedef enum logic [1:0] {WB_SINGLE = 2'd0, WB_PIPE = 2'd1, WB_ITER = 2'd2} FPUWbSel_t;
    typedef struct packed {
        logic      valid;
        RegAddr_t  waddr;
        FPUWbSel_t sel;
    } WbSlot_t;
    function automatic FPUOpClass_t fpu_op_class(FPUOper_t op);
        return op inside {FPU_OP_LW, FPU_OP_SW, FPU_OP_MFC, FPU_OP_CFC, FPU_OP_MTC, FPU_OP_CTC, FPU_OP_COND} ? OPC_SINGLE :
               op inside {FPU_OP_ADD, FPU_OP_SUB, FPU_OP_MUL, FPU_OP_ROUND, FPU_OP_TRUNC, FPU_OP_CEIL,
                          FPU_OP_FLOOR, FPU_OP_CVTS, FPU_OP_CVTW} ? OPC_PIPE :
               op inside {FPU_OP_DIV, FPU_OP_SQRT} ? OPC_ITER : OPC_INVALID;
    endfunction
    // FP source 1 (fs): arithmetic, conversions, SW store data, MFC move source, compares.
    // LW/MTC/CFC/CTC take their operand from the integer side.
    function automatic logic fpu_reads1(FPUOper_t op);
        return op inside {FPU_OP_ADD, FPU_OP_SUB, FPU_OP_MUL, FPU_OP_DIV, FPU_OP_SQRT, FPU_OP_ROUND,
                          FPU_OP_TRUNC, FPU_OP_CEIL, FPU_OP_FLOOR, FPU_OP_CVTS, FPU_OP_CVTW,
                          FPU_OP_SW, FPU_OP_MFC, FPU_OP_COND};
    endfunction
    // FP source 2 (ft): only true two-operand ops.
    function automatic logic fpu_reads2(FPUOper_t op);
        return op inside {FPU_OP_ADD, FPU_OP_SUB, FPU_OP_MUL, FPU_OP_DIV, FPU_OP_COND};
    endfunction
endpackage

// File: rtl/fpu_issue_ctrl_wb_slots.sv
// fpu_wb_slots: writeback reservation shift register, entry k writes back k cycles from now
//   rsv_valid/rsv_pos/rsv_entry : claim entry rsv_pos (post-shift index) this edge
//   flush                       : empty every entry
//   slot1_busy                  : entry 1 taken (next cycle's writeback already claimed)
//   head                        : entry 0, drives the register-file write port
module fpu_wb_slots
    import fpu_issue_ctrl_pkg::*;
#(
    parameter int PIPE_LAT = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        rsv_valid,
    input  logic [$clog2(PIPE_LAT)-1:0] rsv_pos,
    input  WbSlot_t                     rsv_entry,
    output logic                        slot1_busy,
    output WbSlot_t                     head
);
    WbSlot_t [PIPE_LAT-1:0] q, d;
    always_comb begin
        d = q >> $bits(WbSlot_t);
        if (rsv_valid) d[rsv_pos] = rsv_entry;
    end
    always_ff @(posedge clk) begin
        if (rst || flush) q <= '0;
        else q <= d;
    end
    assign slot1_busy = q[1].valid;
    assign head = q[0];
endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: FPU issue scoreboard, DIV/SQRT sequencing and writeback-port arbitration
//   issue_*   : decoded op in, issue_ready = accepted when issue_valid
//   flush     : kill every unwritten result, block issue this cycle
//   iter_*    : start pulse / latched op / done-ack handshake with the DIV/SQRT unit
//   wb_*      : single register-file write port (sel 0 single, 1 pipe, 2 iter)
//   illegal   : pulse the cycle after an invalid op is accepted
//   busy      : any register pending or iterative unit not idle
module fpu_issue_ctrl
    import fpu_issue_ctrl_pkg::*;
#(
    parameter int PIPE_LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  FPUOper_t   issue_op,
    input  RegAddr_t   issue_raddr1,
    input  RegAddr_t   issue_raddr2,
    input  Bit_t       issue_we,
    input  RegAddr_t   issue_waddr,
    output logic       issue_ready,
    input  logic       flush,
    output logic       iter_start,
    output FPUOper_t   iter_op,
    input  logic       iter_done,
    output logic       iter_ack,
    output logic       wb_valid,
    output RegAddr_t   wb_waddr,
    output logic [1:0] wb_sel,
    output logic       illegal,
    output logic       busy
);
    localparam int PW = $clog2(PIPE_LAT);
    typedef enum logic [1:0] {IT_IDLE, IT_RUN, IT_HOLD, IT_DRAIN} iter_state_t;
    iter_state_t state_q, state_d;
    logic [31:0] pending;
    logic        iter_we;
    RegAddr_t    iter_waddr;
    FPUOpClass_t cls;
    logic        eff_we, hazard, slot_ok, accept, iter_wr, slot1_busy, rsv_valid;
    logic [PW-1:0] rsv_pos;
    WbSlot_t     rsv_entry, head;
    always_comb begin
        cls = fpu_op_class(issue_op);
        eff_we = issue_we && cls != OPC_INVALID;
        hazard = (fpu_reads1(issue_op) && pending[issue_raddr1]) ||
                 (fpu_reads2(issue_op) && pending[issue_raddr2]) ||
                 (eff_we && pending[issue_waddr]);
        // Slot PIPE_LAT can only be claimed by the op being accepted now, so PIPE never waits on it.
        slot_ok = !eff_we || cls != OPC_SINGLE || !slot1_busy;
        issue_ready = !rst && !flush && !hazard && slot_ok && (cls != OPC_ITER || state_q == IT_IDLE);
        accept = issue_valid && issue_ready;
        iter_start = accept && cls == OPC_ITER;
        rsv_valid = accept && eff_we && (cls == OPC_SINGLE || cls == OPC_PIPE);
        rsv_pos = cls == OPC_SINGLE ? '0 : PW'(PIPE_LAT - 1);
        rsv_entry = '{valid: 1'b1, waddr: issue_waddr, sel: cls == OPC_SINGLE ? WB_SINGLE : WB_PIPE};
    end
    fpu_wb_slots #(.PIPE_LAT(PIPE_LAT)) u_slots (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .rsv_valid  (rsv_valid),
        .rsv_pos    (rsv_pos),
        .rsv_entry  (rsv_entry),
        .slot1_busy (slot1_busy),
        .head       (head)
    );
    // HOLD yields to a reserved pipeline slot; an iterative op without a destination just acks.
    always_comb begin
        state_d = state_q;
        iter_ack = 1'b0;
        iter_wr = 1'b0;
        case (state_q)
            IT_IDLE:  if (iter_start) state_d = IT_RUN;
            IT_RUN:   state_d = flush ? IT_DRAIN : iter_done ? IT_HOLD : IT_RUN;
            IT_HOLD: begin
                iter_ack = flush || !iter_we || !head.valid;
                iter_wr = iter_ack && !flush && iter_we;
                if (iter_ack) state_d = IT_IDLE;
            end
            IT_DRAIN: begin
                iter_ack = iter_done;
                if (iter_done) state_d = IT_IDLE;
            end
            default:  state_d = IT_IDLE;
        endcase
    end
    assign wb_valid = !flush && (head.valid || iter_wr);
    assign wb_waddr = head.valid ? head.waddr : iter_wr ? iter_waddr : '0;
    assign wb_sel = head.valid ? head.sel : iter_wr ? WB_ITER : WB_SINGLE;
    assign busy = |pending || state_q != IT_IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IT_IDLE;
            pending <= '0;
            iter_op <= FPU_OP_INVALID;
            iter_we <= 1'b0;
            iter_waddr <= '0;
            illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            illegal <= accept && cls == OPC_INVALID;
            if (iter_start) begin
                iter_op <= issue_op;
                iter_we <= issue_we;
                iter_waddr <= issue_waddr;
            end
            // No bypass: a bit leaves the mask only after its write cycle; flush drops all, DRAIN included.
            if (flush) pending <= '0;
            else pending <= (pending & ~(wb_valid ? 32'd1 << wb_waddr : 32'd0)) |
                            (accept && eff_we ? 32'd1 << issue_waddr : 32'd0);
        end
    end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: table-driven directed check of fpu_issue_ctrl
module tb_fpu_issue_ctrl;
    import fpu_issue_ctrl_pkg::*;
    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    FPUOper_t   issue_op;
    RegAddr_t   issue_raddr1, issue_raddr2, issue_waddr;
    Bit_t       issue_we;
    logic       issue_ready, flush, iter_start, iter_done, iter_ack, wb_valid, illegal, busy;
    FPUOper_t   iter_op;
    RegAddr_t   wb_waddr;
    logic [1:0] wb_sel;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    fpu_issue_ctrl #(.PIPE_LAT(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_op     (issue_op),
        .issue_raddr1 (issue_raddr1),
        .issue_raddr2 (issue_raddr2),
        .issue_we     (issue_we),
        .issue_waddr  (issue_waddr),
        .issue_ready  (issue_ready),
        .flush        (flush),
        .iter_start   (iter_start),
        .iter_op      (iter_op),
        .iter_done    (iter_done),
        .iter_ack     (iter_ack),
        .wb_valid     (wb_valid),
        .wb_waddr     (wb_waddr),
        .wb_sel       (wb_sel),
        .illegal      (illegal),
        .busy         (busy)
    );
    typedef struct {
        logic vld; FPUOper_t op; RegAddr_t r1, r2; logic we; RegAddr_t wa; logic fl, dn;
        logic rdy, wbv; RegAddr_t wba; logic [1:0] sel; logic st, ack, ill, bsy;
    } vec_t;
    vec_t vecs[$];
    task automatic v(input int vld, input FPUOper_t op, input int r1, r2, we, wa, fl, dn,
                     rdy, wbv, wba, sel, st, ack, ill, bsy);
        vecs.push_back('{1'(vld), op, 5'(r1), 5'(r2), 1'(we), 5'(wa), 1'(fl), 1'(dn),
                         1'(rdy), 1'(wbv), 5'(wba), 2'(sel), 1'(st), 1'(ack), 1'(ill), 1'(bsy)});
    endtask
    task automatic nop(input int fl, dn, rdy, wbv, wba, sel, ack, ill, bsy);
        v(0, FPU_OP_INVALID, 0, 0, 0, 0, fl, dn, rdy, wbv, wba, sel, 0, ack, ill, bsy);
    endtask
    task automatic chk(input int k, input string n, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL step %0d %s: got %0h expected %0h", k, n, act, exp);
        end
    endtask
    task automatic drive(input logic vld, input FPUOper_t op, input int r1, we, wa);
        issue_valid = vld;
        issue_op = op;
        issue_raddr1 = 5'(r1);
        issue_raddr2 = 5'd0;
        issue_we = 1'(we);
        issue_waddr = 5'(wa);
        flush = 1'b0;
        iter_done = 1'b0;
    endtask
    initial begin
        rst = 1'b1;
        drive(1'b0, FPU_OP_INVALID, 0, 0, 0);
        // ADD f3 then dependent SUB, pipe latency 3
        v(1, FPU_OP_ADD, 1, 2, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) v(1, FPU_OP_SUB, 3, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        v(1, FPU_OP_SUB, 3, 1, 1, 7, 0, 0, 0, 1, 3, 1, 0, 0, 0, 1);
        v(1, FPU_OP_SUB, 3, 1, 1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) nop(0, 0, 1, 0, 0, 0, 0, 0, 1);
        nop(0, 0, 1, 1, 7, 1, 0, 0, 1);
        nop(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // MUL then MTC colliding on slot 1
        v(1, FPU_OP_MUL, 1, 2, 1, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        nop(0, 0, 1, 0, 0, 0, 0, 0, 1);
        v(1, FPU_OP_MTC, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        v(1, FPU_OP_MTC, 0, 0, 1, 5, 0, 0, 1, 1, 4, 1, 0, 0, 0, 1);
        nop(0, 0, 1, 1, 5, 0, 0, 0, 1);
        nop(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // invalid op: accepted, illegal next cycle, f9 never pending
        v(1, FPU_OP_INVALID, 0, 0, 1, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        nop(0, 0, 1, 0, 0, 0, 0, 1, 0);
        v(1, FPU_OP_ADD, 9, 9, 1, 10, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) nop(0, 0, 1, 0, 0, 0, 0, 0, 1);
        nop(0, 0, 1, 1, 10, 1, 0, 0, 1);
        nop(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // DIV f6, second DIV waits for IDLE
        v(1, FPU_OP_DIV, 1, 2, 1, 6, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        repeat (8) v(1, FPU_OP_DIV, 1, 2, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        v(1, FPU_OP_DIV, 1, 2, 1, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        v(1, FPU_OP_DIV, 1, 2, 1, 8, 0, 1, 0, 1, 6, 2, 0, 1, 0, 1);
        v(1, FPU_OP_DIV, 1, 2, 1, 8, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        // iterative result held behind a pipe writeback
        v(1, FPU_OP_ADD, 1, 2, 1, 11, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        nop(0, 0, 1, 0, 0, 0, 0, 0, 1);
        nop(0, 1, 1, 0, 0, 0, 0, 0, 1);
        nop(0, 1, 1, 1, 11, 1, 0, 0, 1);
        nop(0, 1, 1, 1, 8, 2, 1, 0, 1);
        nop(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // flush with ADD in flight and DIV running -> DRAIN
        v(1, FPU_OP_DIV, 1, 2, 1, 12, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        v(1, FPU_OP_ADD, 1, 2, 1, 13, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        nop(1, 0, 0, 0, 0, 0, 0, 0, 1);
        v(1, FPU_OP_ADD, 13, 12, 1, 14, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) nop(0, 0, 1, 0, 0, 0, 0, 0, 1);
        nop(0, 0, 1, 1, 14, 1, 0, 0, 1);
        nop(0, 0, 1, 0, 0, 0, 0, 0, 1);
        nop(0, 1, 1, 0, 0, 0, 1, 0, 1);
        nop(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // flush while HOLD is blocked by a pipe slot: ack without write
        v(1, FPU_OP_ADD, 1, 2, 1, 16, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        v(1, FPU_OP_DIV, 1, 2, 1, 15, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1);
        nop(0, 1, 1, 0, 0, 0, 0, 0, 1);
        nop(1, 1, 0, 0, 0, 0, 1, 0, 1);
        nop(0, 0, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk(-1, "rst_wb_valid", 32'(wb_valid), 0);
        chk(-1, "rst_wb_waddr", 32'(wb_waddr), 0);
        chk(-1, "rst_wb_sel", 32'(wb_sel), 0);
        chk(-1, "rst_iter_op", 32'(iter_op), 32'(FPU_OP_INVALID));
        chk(-1, "rst_iter_start", 32'(iter_start), 0);
        chk(-1, "rst_iter_ack", 32'(iter_ack), 0);
        chk(-1, "rst_illegal", 32'(illegal), 0);
        chk(-1, "rst_busy", 32'(busy), 0);
        rst = 1'b0;
        foreach (vecs[k]) begin
            @(negedge clk);
            issue_valid = vecs[k].vld;
            issue_op = vecs[k].op;
            issue_raddr1 = vecs[k].r1;
            issue_raddr2 = vecs[k].r2;
            issue_we = vecs[k].we;
            issue_waddr = vecs[k].wa;
            flush = vecs[k].fl;
            iter_done = vecs[k].dn;
            #1;
            chk(k, "issue_ready", 32'(issue_ready), 32'(vecs[k].rdy));
            chk(k, "wb_valid", 32'(wb_valid), 32'(vecs[k].wbv));
            if (vecs[k].wbv) begin
                chk(k, "wb_waddr", 32'(wb_waddr), 32'(vecs[k].wba));
                chk(k, "wb_sel", 32'(wb_sel), 32'(vecs[k].sel));
            end
            chk(k, "iter_start", 32'(iter_start), 32'(vecs[k].st));
            chk(k, "iter_ack", 32'(iter_ack), 32'(vecs[k].ack));
            chk(k, "illegal", 32'(illegal), 32'(vecs[k].ill));
            chk(k, "busy", 32'(busy), 32'(vecs[k].bsy));
        end
        // SQRT latched into iter_op, then reset mid-RUN: back to idle with no ack
        @(negedge clk);
        drive(1'b1, FPU_OP_SQRT, 1, 1, 20);
        #1;
        chk(100, "sqrt_start", 32'(iter_start), 1);
        @(negedge clk);
        drive(1'b0, FPU_OP_INVALID, 0, 0, 0);
        #1;
        chk(101, "sqrt_iter_op", 32'(iter_op), 32'(FPU_OP_SQRT));
        chk(101, "sqrt_busy", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk(102, "midrst_busy", 32'(busy), 0);
        chk(102, "midrst_ack", 32'(iter_ack), 0);
        chk(102, "midrst_iter_op", 32'(iter_op), 32'(FPU_OP_INVALID));
        rst = 1'b0;
        @(negedge clk);
        drive(1'b1, FPU_OP_DIV, 20, 1, 20);
        #1;
        chk(103, "postrst_ready", 32'(issue_ready), 1);
        chk(103, "postrst_start", 32'(iter_start), 1);
        @(negedge clk);
        drive(1'b0, FPU_OP_INVALID, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
